rr_frame_arb: RTL



---
 rtl/rr_frame_arb.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/rr_frame_arb.sv
// Frame-locked round-robin arbiter with registered one-hot/binary grant.
// Optional watchdog release enabled by defining RR_FRAME_ARB_TIMEOUT_EN.
module rr_frame_arb_penc #(
   parameter int W  = 4,
   parameter int IW = 2
) (
   input  logic [W-1:0]  in_i,
   output logic          vld_o,
   output logic [IW-1:0] idx_o
);

   // Scan high to low so the lowest set index is the last one written.
   always_comb begin
      vld_o = 1'b0;
      idx_o = '0;
      for (int i = W - 1; i >= 0; i--) begin
         if (in_i[i]) begin
            vld_o = 1'b1;
            idx_o = IW'(i);
         end
      end
   end

endmodule

module rr_frame_arb #(
   parameter int NUM_PORTS      = 4,
   parameter int NUM_PORTS_L2   = $clog2(NUM_PORTS),
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_PORTS-1:0]    req,
   input  logic                    sink_rdy,
   input  logic                    xfer_last,
   output logic [NUM_PORTS-1:0]    gnt_vec,
   output logic [NUM_PORTS_L2-1:0] gnt_bin,
   output logic                    gnt_vld,
   output logic                    arb_timeout
);

   localparam int P = 1 << NUM_PORTS_L2;

   typedef enum logic {
      IDLE,
      GRANT
   } state_t;

   state_t                  state_q, state_d;
   logic [NUM_PORTS-1:0]    gnt_vec_q, gnt_vec_d;
   logic [NUM_PORTS_L2-1:0] gnt_bin_q, gnt_bin_d;
   logic                    gnt_vld_q, gnt_vld_d;
   logic [NUM_PORTS_L2-1:0] last_ptr_q, last_ptr_d;

   logic [P-1:0]            req_pad;
   logic [P-1:0]            mask_pad;
   logic                    m_vld, u_vld;
   logic [NUM_PORTS_L2-1:0] m_idx, u_idx;
   logic [NUM_PORTS_L2-1:0] win_bin;
   logic [NUM_PORTS-1:0]    win_vec;
   logic                    frame_end;
   logic                    tmo_hit;
   logic                    tmo_rel;

   // Pad to a power of two; the extra encoder inputs stay 0.
   always_comb begin
      req_pad  = '0;
      mask_pad = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         req_pad[i]  = req[i];
         mask_pad[i] = req[i] && (i > int'(last_ptr_q));
      end
   end

   rr_frame_arb_penc #(
      .W  (P),
      .IW (NUM_PORTS_L2)
   ) u_penc_mask (
      .in_i  (mask_pad),
      .vld_o (m_vld),
      .idx_o (m_idx)
   );

   rr_frame_arb_penc #(
      .W  (P),
      .IW (NUM_PORTS_L2)
   ) u_penc_req (
      .in_i  (req_pad),
      .vld_o (u_vld),
      .idx_o (u_idx)
   );

   assign win_bin   = m_vld ? m_idx : u_idx;
   assign win_vec   = NUM_PORTS'(1) << win_bin;
   assign frame_end = sink_rdy && xfer_last;
   assign tmo_rel   = (state_q == GRANT) && !frame_end && tmo_hit;

`ifdef RR_FRAME_ARB_TIMEOUT_EN
   localparam int CW_RAW = $clog2(TIMEOUT_CYCLES);
   localparam int CW     = (CW_RAW > 16) ? CW_RAW : 16;

   logic [CW-1:0] cnt_q, cnt_d;
   logic          tmo_q;

   assign tmo_hit = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

   // Held at zero in IDLE so every new grant starts from a cleared count.
   always_comb begin
      cnt_d = cnt_q;
      if (state_q == IDLE) begin
         cnt_d = '0;
      end else if (sink_rdy) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         tmo_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         tmo_q <= tmo_rel;
      end
   end

   assign arb_timeout = tmo_q;
`else
   logic unused_tmo;

   assign tmo_hit     = 1'b0;
   assign unused_tmo  = ^{TIMEOUT_CYCLES, tmo_rel};
   assign arb_timeout = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      gnt_vec_d  = gnt_vec_q;
      gnt_bin_d  = gnt_bin_q;
      gnt_vld_d  = gnt_vld_q;
      last_ptr_d = last_ptr_q;
      unique case (state_q)
         IDLE: begin
            if (u_vld) begin
               state_d    = GRANT;
               gnt_vec_d  = win_vec;
               gnt_bin_d  = win_bin;
               gnt_vld_d  = 1'b1;
               last_ptr_d = win_bin;
            end
         end
         GRANT: begin
            // last_ptr keeps the released port, so it loses the next round.
            if (frame_end || tmo_hit) begin
               state_d   = IDLE;
               gnt_vec_d = '0;
               gnt_bin_d = '0;
               gnt_vld_d = 1'b0;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         gnt_vec_q  <= '0;
         gnt_bin_q  <= '0;
         gnt_vld_q  <= 1'b0;
         last_ptr_q <= NUM_PORTS_L2'(NUM_PORTS - 1);
      end else begin
         state_q    <= state_d;
         gnt_vec_q  <= gnt_vec_d;
         gnt_bin_q  <= gnt_bin_d;
         gnt_vld_q  <= gnt_vld_d;
         last_ptr_q <= last_ptr_d;
      end
   end

   assign gnt_vec = gnt_vec_q;
   assign gnt_bin = gnt_bin_q;
   assign gnt_vld = gnt_vld_q;

endmodule
